// File: rtl/avalon_mem_arbiter.sv
// Two-master (CPU / HPS Avalon) arbiter in front of one single-port 32-bit data RAM.
// Define AVALON_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise the CPU always wins ties.
module avalon_mem_arbiter #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clock,
  input  logic              reset,
  // CPU data port
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [3:0]        cpu_be,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ack,
  // HPS Avalon conduit
  input  logic [23:0]       avalon_address,
  input  logic [3:0]        avalon_byte_enable,
  input  logic              avalon_read,
  input  logic              avalon_write,
  input  logic [31:0]       avalon_write_data,
  output logic [31:0]       avalon_read_data,
  output logic              avalon_acknowledge,
  // Data RAM
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_be,
  output logic              ram_we,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [7:0]        err_count
);

  typedef enum logic [1:0] {
    StIdle,
    StResp,
    StAck
  } state_e;

  state_e state_q, state_d;

  logic              grant;
  logic              capture;
  logic              cpu_req;
  logic              hps_req;
  logic              tie_to_hps;
  logic              win_hps;
  logic              sel_write;
  logic              sel_oor;
  logic              ram_access;
  logic [ADDR_W-1:0] sel_addr;
  logic [3:0]        sel_be;
  logic [31:0]       sel_wdata;

  logic [21:0]       hps_word;
  logic [21:0]       hps_word_hi;
  logic              hps_oor;

  logic              owner_q;  // 0: CPU, 1: HPS
  logic              oor_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [3:0]        ram_be_q;
  logic [31:0]       ram_wdata_q;
  logic [31:0]       cpu_rdata_q;
  logic [31:0]       hps_rdata_q;
  logic              cpu_ack_q;
  logic              hps_ack_q;
  logic [7:0]        err_q;

  logic              unused_addr_lsbs;
  assign unused_addr_lsbs = ^avalon_address[1:0];

  // Request decode and out-of-range detection
  assign cpu_req     = cpu_read | cpu_write;
  assign hps_req     = avalon_read | avalon_write;
  assign hps_word    = avalon_address[23:2];
  assign hps_word_hi = hps_word >> ADDR_W;
  assign hps_oor     = |hps_word_hi;

`ifdef AVALON_ARB_ROUND_ROBIN_EN
  logic last_grant_q;  // 0: CPU, 1: HPS

  assign tie_to_hps = ~last_grant_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant_q <= 1'b1;
    end else if (grant) begin
      last_grant_q <= win_hps;
    end
  end
`else
  assign tie_to_hps = 1'b0;
`endif

  assign win_hps = hps_req & (~cpu_req | tie_to_hps);

  // Winner mux; a simultaneous read+write is a write
  assign sel_addr   = win_hps ? hps_word[ADDR_W-1:0] : cpu_addr;
  assign sel_be     = win_hps ? avalon_byte_enable   : cpu_be;
  assign sel_wdata  = win_hps ? avalon_write_data    : cpu_wdata;
  assign sel_write  = win_hps ? avalon_write         : cpu_write;
  assign sel_oor    = win_hps & hps_oor;
  assign ram_access = grant & ~sel_oor;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    capture = 1'b0;
    case (state_q)
      StIdle: begin
        // Reset gating keeps the RAM quiet while reset is held with requests pending
        if (!reset && (cpu_req || hps_req)) begin
          grant   = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        capture = 1'b1;
        state_d = StAck;
      end
      StAck: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      owner_q     <= 1'b0;
      oor_q       <= 1'b0;
      ram_addr_q  <= '0;
      ram_be_q    <= '0;
      ram_wdata_q <= '0;
      cpu_rdata_q <= '0;
      hps_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      hps_ack_q   <= 1'b0;
      err_q       <= '0;
    end else begin
      cpu_ack_q <= capture & ~owner_q;
      hps_ack_q <= capture & owner_q;

      if (grant) begin
        owner_q <= win_hps;
        oor_q   <= sel_oor;
        if (sel_oor && (err_q != 8'hFF)) begin
          err_q <= err_q + 8'd1;
        end
      end

      if (ram_access) begin
        ram_addr_q  <= sel_addr;
        ram_be_q    <= sel_be;
        ram_wdata_q <= sel_wdata;
      end

      if (capture) begin
        if (owner_q) begin
          hps_rdata_q <= oor_q ? 32'h0 : ram_rdata;
        end else begin
          cpu_rdata_q <= ram_rdata;
        end
      end
    end
  end

  // RAM port: live winner values in the grant cycle, held values otherwise
  assign ram_addr  = ram_access ? sel_addr  : ram_addr_q;
  assign ram_be    = ram_access ? sel_be    : ram_be_q;
  assign ram_wdata = ram_access ? sel_wdata : ram_wdata_q;
  assign ram_we    = ram_access & sel_write;

  assign cpu_rdata          = cpu_rdata_q;
  assign cpu_ack            = cpu_ack_q;
  assign avalon_read_data   = hps_rdata_q;
  assign avalon_acknowledge = hps_ack_q;
  assign err_count          = err_q;

endmodule
